// File: rtl/return_link_stack.sv
// Bounded return-address stack for the fetch path: pushes npc on a call,
// presents the saved address on rl for a return, and reports overflow/underflow.
module return_link_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 10
) (
  input  logic                   clk,
  input  logic                   start_n,
  input  logic                   jump2sub,
  input  logic                   retFsub,
  input  logic [AW-1:0]          npc,
  input  logic                   clr_flags,
  output logic [AW-1:0]          rl,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_ev;
  logic          unf_ev;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  // Decode status from registered state; a call always takes priority over a return.
  always_comb begin
    empty   = (count == CW'(0));
    full    = (count == CW'(DEPTH));
    push_ok = jump2sub && !full;
    ovf_ev  = jump2sub && full;
    pop_ok  = retFsub && !jump2sub && !empty;
    unf_ev  = retFsub && !jump2sub && empty;
    wr_idx  = count[IW-1:0];
    top_idx = IW'(count - CW'(1));
    rl      = '0;
    if (!empty) begin
      rl = mem[top_idx];
    end
  end

  // Entries carry no reset; an empty stack masks them on rl.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= npc;
    end
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok) begin
        count <= count - CW'(1);
      end
      // A new event in the same cycle as a clear keeps the flag set.
      overflow  <= ovf_ev || (overflow && !clr_flags);
      underflow <= unf_ev || (underflow && !clr_flags);
    end
  end

endmodule
